drop_draw_ctrl: RTL and testbench

- Upstream sequencer for the 16x16 piece-sprite drawer in the Connect Four datapath.
- Accepts a column drop request from the game FSM and owns the 7x6 occupancy/colour board.
- Computes the landing cell, then drives the drawer's draw-red/draw-blue strobes and sprite origin for one full sprite pass.
- Drives the VGA plot enable aligned to the drawer's one-cycle ROM latency.

---
 rtl/drop_draw_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_drop_draw_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_draw_ctrl.sv
// -----------------------------------------------------------------------------
// drop_draw_ctrl
//   Upstream sequencer for the 16x16 piece-sprite drawer. Owns the 7x6
//   Connect Four board (occupancy, colour, column heights), resolves a column
//   drop to its landing cell, then holds the draw-red/draw-blue strobe and the
//   sprite origin for one full sprite pass. plot follows the strobe by one
//   cycle to line up with the drawer's ROM read latency.
//
//   Optional feature: define WIN_DETECT_EN to add a CHECK state that looks
//   for four-in-a-row through the placed cell and raises a sticky win flag.
//
// Ports
//   clk         system clock
//   resetn      synchronous, active-low reset
//   drop_req    drop request (only looked at while idle)
//   drop_col    target column 0..6 (7 is rejected)
//   player      0 = red, 1 = blue
//   clear_req   clear the board (only looked at while idle, beats drop_req)
//   drop_ack    one-cycle pulse, drop accepted
//   drop_rej    one-cycle pulse, drop rejected
//   busy        request in progress
//   drawr/drawb draw strobes to the sprite drawer
//   xin/yin     sprite origin
//   plot        VGA write enable
//   done        one-cycle pulse, sprite fully drawn
//   board_full  all 42 cells occupied
//   win         four-in-a-row by last mover (0 unless WIN_DETECT_EN)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for clear_req / drop_req
// LOAD  | resolve landing cell, ack or reject, latch sprite origin
// DRAW  | strobe held for DRAW_CYCLES cycles
// FLUSH | strobe off, last plot cycle for the ROM latency
// CHECK | four-in-a-row test through the placed cell (WIN_DETECT_EN only)
// DONE  | done pulse
// -----------------------------------------------------------------------------
module drop_draw_ctrl #(
   parameter int unsigned X0          = 24,
   parameter int unsigned Y0          = 12,
   parameter int unsigned DRAW_CYCLES = 256
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       drop_req,
   input  logic [2:0] drop_col,
   input  logic       player,
   input  logic       clear_req,
   output logic       drop_ack,
   output logic       drop_rej,
   output logic       busy,
   output logic       drawr,
   output logic       drawb,
   output logic [7:0] xin,
   output logic [6:0] yin,
   output logic       plot,
   output logic       done,
   output logic       board_full,
   output logic       win
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAW  = 3'd2,
      S_FLUSH = 3'd3,
      S_CHECK = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [8:0] CNT_LAST = 9'(DRAW_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  col_q, col_d;
   logic        player_q, player_d;
   logic [2:0]  row_q, row_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [7:0]  xin_q, xin_d;
   logic [6:0]  yin_q, yin_d;
   logic        plot_q;
   logic [41:0] occ_q, occ_d;
   logic [41:0] colof_q, colof_d;
   logic [2:0]  h_q [7];
   logic [2:0]  h_d [7];
   logic        board_full_q, board_full_d;

   logic [2:0]  h_sel;
   logic [2:0]  row_diff;
   logic [5:0]  cell_idx;
   logic        load_rej;
   logic        win_w;

`ifdef WIN_DETECT_EN
   logic win_q, win_d;
   logic win_hit;

   // Number of consecutive cells of colour p stepping away from (r,c) in
   // direction (dr,dc), stopping at the first mismatch or the board edge.
   function automatic int run_len(input logic [41:0] occ, input logic [41:0] cof,
                                  input logic p, input int r, input int c,
                                  input int dr, input int dc);
      int         n;
      int         rr;
      int         cc;
      logic       go;
      logic [5:0] idx;
      n  = 0;
      go = 1'b1;
      for (int s = 1; s <= 3; s++) begin
         rr  = r + dr * s;
         cc  = c + dc * s;
         idx = 6'(rr * 7 + cc);
         if (go && rr >= 0 && rr <= 5 && cc >= 0 && cc <= 6 && occ[idx] && (cof[idx] == p))
            n = n + 1;
         else
            go = 1'b0;
      end
      return n;
   endfunction

   function automatic logic line_hit(input logic [41:0] occ, input logic [41:0] cof,
                                     input logic p, input int r, input int c,
                                     input int dr, input int dc);
      return (run_len(occ, cof, p, r, c, dr, dc) + run_len(occ, cof, p, r, c, -dr, -dc)) >= 3;
   endfunction

   // Board registers already hold the placed cell by the time CHECK runs.
   assign win_hit = line_hit(occ_q, colof_q, player_q, int'(row_q), int'(col_q), 0, 1)
                 || line_hit(occ_q, colof_q, player_q, int'(row_q), int'(col_q), 1, 0)
                 || line_hit(occ_q, colof_q, player_q, int'(row_q), int'(col_q), 1, 1)
                 || line_hit(occ_q, colof_q, player_q, int'(row_q), int'(col_q), 1, -1);
   assign win_w = win_q;
`else
   assign win_w = 1'b0;
`endif

   // Column 7 reads as full so the landing math never indexes past the board.
   assign h_sel    = (col_q == 3'd7) ? 3'd6 : h_q[col_q];
   assign row_diff = 3'd5 - h_sel;
   assign cell_idx = 6'(h_sel) * 6'd7 + 6'(col_q);
   assign load_rej = (col_q == 3'd7) || (h_sel == 3'd6) || win_w;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      player_d = player_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      xin_d    = xin_q;
      yin_d    = yin_q;
      occ_d    = occ_q;
      colof_d  = colof_q;
      for (int i = 0; i < 7; i++) h_d[i] = h_q[i];
`ifdef WIN_DETECT_EN
      win_d    = win_q;
`endif
      drop_ack = 1'b0;
      drop_rej = 1'b0;
      drawr    = 1'b0;
      drawb    = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               occ_d   = '0;
               colof_d = '0;
               for (int i = 0; i < 7; i++) h_d[i] = 3'd0;
`ifdef WIN_DETECT_EN
               win_d   = 1'b0;
`endif
            end else if (drop_req) begin
               col_d    = drop_col;
               player_d = player;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_rej) begin
               drop_rej = 1'b1;
               state_d  = S_IDLE;
            end else begin
               drop_ack          = 1'b1;
               occ_d[cell_idx]   = 1'b1;
               colof_d[cell_idx] = player_q;
               h_d[col_q]        = h_sel + 3'd1;
               row_d             = h_sel;
               xin_d             = 8'(X0) + {1'b0, col_q, 4'b0000};
               yin_d             = 7'(Y0) + {row_diff, 4'b0000};
               cnt_d             = '0;
               state_d           = S_DRAW;
            end
         end
         S_DRAW: begin
            drawr = ~player_q;
            drawb = player_q;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_FLUSH;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         S_FLUSH: begin
`ifdef WIN_DETECT_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
         end
         S_CHECK: begin
`ifdef WIN_DETECT_EN
            win_d = win_q | win_hit;
`endif
            state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      board_full_d = 1'b1;
      for (int i = 0; i < 7; i++)
         if (h_d[i] != 3'd6) board_full_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         player_q     <= 1'b0;
         row_q        <= '0;
         cnt_q        <= '0;
         xin_q        <= '0;
         yin_q        <= '0;
         plot_q       <= 1'b0;
         occ_q        <= '0;
         colof_q      <= '0;
         for (int i = 0; i < 7; i++) h_q[i] <= 3'd0;
         board_full_q <= 1'b0;
`ifdef WIN_DETECT_EN
         win_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         player_q     <= player_d;
         row_q        <= row_d;
         cnt_q        <= cnt_d;
         xin_q        <= xin_d;
         yin_q        <= yin_d;
         plot_q       <= drawr | drawb;
         occ_q        <= occ_d;
         colof_q      <= colof_d;
         for (int i = 0; i < 7; i++) h_q[i] <= h_d[i];
         board_full_q <= board_full_d;
`ifdef WIN_DETECT_EN
         win_q        <= win_d;
`endif
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign xin        = xin_q;
   assign yin        = yin_q;
   assign plot       = plot_q;
   assign board_full = board_full_q;
   assign win        = win_w;

endmodule

// File: tb/tb_drop_draw_ctrl.sv
`timescale 1ns/1ps
module tb_drop_draw_ctrl;

   localparam int DC = 256;
`ifdef WIN_DETECT_EN
   localparam int DONEK  = DC + 4;
   localparam bit WIN_ON = 1'b1;
`else
   localparam int DONEK  = DC + 3;
   localparam bit WIN_ON = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_ACC  = 1;
   localparam int M_REJ  = 2;

   logic       clk       = 1'b0;
   logic       resetn    = 1'b0;
   logic       drop_req  = 1'b0;
   logic [2:0] drop_col  = 3'd0;
   logic       player    = 1'b0;
   logic       clear_req = 1'b0;
   logic       drop_ack, drop_rej, busy, drawr, drawb, plot, done, board_full, win;
   logic [7:0] xin;
   logic [6:0] yin;

   drop_draw_ctrl dut (
      .clk(clk), .resetn(resetn), .drop_req(drop_req), .drop_col(drop_col),
      .player(player), .clear_req(clear_req), .drop_ack(drop_ack), .drop_rej(drop_rej),
      .busy(busy), .drawr(drawr), .drawb(drawb), .xin(xin), .yin(yin), .plot(plot),
      .done(done), .board_full(board_full), .win(win)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   // Behavioural model: board as columns of stacked colours, plus the
   // request timeline measured in cycles since the request was sampled.
   int mh [7];
   int mcell [7][6];
   int mode = M_IDLE;
   int k    = 0;
   int px = 0, py = 0, pp = 0, ex = 0, ey = 0;
   bit pwin = 0, efull = 0, ewin = 0;
   bit e_busy = 0, e_ack = 0, e_rej = 0, e_drawr = 0, e_drawb = 0, e_plot = 0, e_done = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic bit board_win();
      int dr [4];
      int dc [4];
      bit found;
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      found = 1'b0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            for (int d = 0; d < 4; d++) begin
               bit ok;
               int colr;
               colr = mcell[c][r];
               ok = (colr >= 0);
               for (int i = 1; i < 4; i++) begin
                  int rr, cc;
                  rr = r + dr[d] * i;
                  cc = c + dc[d] * i;
                  if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
                  else if (mcell[cc][rr] != colr) ok = 1'b0;
               end
               if (ok) found = 1'b1;
            end
      return found;
   endfunction

   function automatic bit all_full();
      bit f;
      f = 1'b1;
      for (int c = 0; c < 7; c++) if (mh[c] != 6) f = 1'b0;
      return f;
   endfunction

   task automatic model_clear_board();
      for (int c = 0; c < 7; c++) begin
         mh[c] = 0;
         for (int r = 0; r < 6; r++) mcell[c][r] = -1;
      end
   endtask

   // Advance the model across one rising edge using the inputs of the cycle
   // that just ended.
   task automatic model_step();
      int col, row;
      if (!resetn) begin
         model_clear_board();
         mode = M_IDLE; k = 0; ex = 0; ey = 0; efull = 0; ewin = 0;
      end else if (mode == M_IDLE) begin
         if (clear_req) begin
            model_clear_board();
            efull = 0; ewin = 0;
         end else if (drop_req) begin
            col = int'(drop_col);
            if (col > 6 || ewin) begin
               mode = M_REJ; k = 1;
            end else if (mh[col] == 6) begin
               mode = M_REJ; k = 1;
            end else begin
               row = mh[col];
               mcell[col][row] = int'(player);
               mh[col] = row + 1;
               px   = (24 + col * 16) & 255;
               py   = (12 + (5 - row) * 16) & 127;
               pp   = int'(player);
               pwin = board_win();
               mode = M_ACC; k = 1;
            end
         end
      end else begin
         k++;
         if (mode == M_ACC && k == 2) begin
            ex = px; ey = py; efull = all_full();
         end
         if (mode == M_ACC && k == DONEK && WIN_ON) ewin = pwin;
         if ((mode == M_REJ && k > 1) || (mode == M_ACC && k > DONEK)) begin
            mode = M_IDLE; k = 0;
         end
      end
      e_busy  = (mode != M_IDLE);
      e_ack   = (mode == M_ACC) && (k == 1);
      e_rej   = (mode == M_REJ) && (k == 1);
      e_drawr = (mode == M_ACC) && (k >= 2) && (k <= DC + 1) && (pp == 0);
      e_drawb = (mode == M_ACC) && (k >= 2) && (k <= DC + 1) && (pp == 1);
      e_plot  = (mode == M_ACC) && (k >= 3) && (k <= DC + 2);
      e_done  = (mode == M_ACC) && (k == DONEK);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",       int'(busy),       int'(e_busy));
         chk("drop_ack",   int'(drop_ack),   int'(e_ack));
         chk("drop_rej",   int'(drop_rej),   int'(e_rej));
         chk("drawr",      int'(drawr),      int'(e_drawr));
         chk("drawb",      int'(drawb),      int'(e_drawb));
         chk("plot",       int'(plot),       int'(e_plot));
         chk("done",       int'(done),       int'(e_done));
         chk("xin",        int'(xin),        ex);
         chk("yin",        int'(yin),        ey);
         chk("board_full", int'(board_full), int'(efull));
         chk("win",        int'(win),        int'(ewin));
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (mode == M_IDLE && !busy) break;
         tick();
      end
      chk("idle_after_request", int'(busy), 0);
   endtask

   task automatic do_drop(input int col, input bit p, output bit a_ack, output bit a_rej,
                          output bit a_busy2, output bit a_draw2, output int a_y2);
      drop_col = 3'(col);
      player   = p;
      drop_req = 1'b1;
      tick();
      drop_req = 1'b0;
      a_ack = drop_ack;
      a_rej = drop_rej;
      tick();
      a_busy2 = busy;
      a_draw2 = drawr | drawb;
      a_y2    = int'(yin);
      wait_idle();
   endtask

   task automatic do_clear();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
   endtask

   initial begin
      bit a_ack, a_rej, a_b2, a_d2;
      int a_y, k1, dk, nr, np, nb, nacc, ndone;
      int ysteps [6];
      ysteps = '{92, 76, 60, 44, 28, 12};

      // reset
      resetn = 1'b0;
      tick();
      chk_en = 1'b1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_xin", int'(xin), 0);
      tick();
      resetn = 1'b1;
      tick();

      // 1: single red drop into column 3
      drop_col = 3'd3; player = 1'b0; drop_req = 1'b1;
      tick();
      drop_req = 1'b0;
      chk("t1_ack", int'(drop_ack), 1);
      k1 = 1; dk = -1; nr = 0; np = 0; nb = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         k1++;
         if (drawr) nr++;
         if (drawb) nb++;
         if (plot) np++;
         if (k1 == 2) begin
            chk("t1_xin", int'(xin), 72);
            chk("t1_yin", int'(yin), 92);
         end
         if (done) begin
            dk = k1;
            break;
         end
      end
      chk("t1_done_latency", dk, WIN_ON ? 260 : 259);
      chk("t1_drawr_cycles", nr, 256);
      chk("t1_drawb_cycles", nb, 0);
      chk("t1_plot_cycles", np, 256);
      wait_idle();

      // 2: fill column 0 then overflow it
      for (int i = 0; i < 6; i++) begin
         do_drop(0, i[0], a_ack, a_rej, a_b2, a_d2, a_y);
         chk("t2_ack", int'(a_ack), 1);
         chk("t2_yin", a_y, ysteps[i]);
      end
      do_drop(0, 1'b0, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t2_full_rej", int'(a_rej), 1);
      chk("t2_full_noack", int'(a_ack), 0);
      chk("t2_full_busy_t2", int'(a_b2), 0);
      chk("t2_full_nodraw", int'(a_d2), 0);

      // 3: bad column, then clear beats a simultaneous drop
      do_drop(7, 1'b1, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t3_col7_rej", int'(a_rej), 1);
      do_drop(3, 1'b1, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t3_col3_row1_yin", a_y, 76);
      drop_col = 3'd3; clear_req = 1'b1; drop_req = 1'b1;
      tick();
      clear_req = 1'b0; drop_req = 1'b0;
      chk("t3_clr_noack", int'(drop_ack), 0);
      chk("t3_clr_norej", int'(drop_rej), 0);
      chk("t3_clr_idle", int'(busy), 0);
      tick();
      do_drop(3, 1'b0, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t3_after_clear_yin", a_y, 92);

      // 4: reset in the middle of a draw
      do_clear();
      drop_col = 3'd2; player = 1'b1; drop_req = 1'b1;
      tick();
      drop_req = 1'b0;
      tick();
      for (int i = 0; i < 100; i++) tick();
      resetn = 1'b0;
      tick();
      chk("t4_rst_drawb", int'(drawb), 0);
      chk("t4_rst_plot", int'(plot), 0);
      chk("t4_rst_yin", int'(yin), 0);
      resetn = 1'b1;
      ndone = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("t4_no_done", ndone, 0);
      do_drop(2, 1'b1, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t4_row0_yin", a_y, 92);

      // 5: fill the board with no four-in-a-row
      do_clear();
      nacc = 0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) begin
            do_drop(c, 1'(((r >> 1) + c) & 1), a_ack, a_rej, a_b2, a_d2, a_y);
            if (a_ack) nacc++;
         end
      chk("t5_acks", nacc, 42);
      chk("t5_board_full", int'(board_full), 1);
      do_drop(4, 1'b0, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t5_extra_rej", int'(a_rej), 1);
      do_clear();
      chk("t5_full_cleared", int'(board_full), 0);

`ifdef WIN_DETECT_EN
      // 6: horizontal red win in the bottom row
      for (int i = 0; i < 4; i++) begin
         do_drop(i, 1'b0, a_ack, a_rej, a_b2, a_d2, a_y);
         if (i < 3) do_drop(6, 1'b1, a_ack, a_rej, a_b2, a_d2, a_y);
      end
      chk("t6_win", int'(win), 1);
      do_drop(5, 1'b1, a_ack, a_rej, a_b2, a_d2, a_y);
      chk("t6_rej_after_win", int'(a_rej), 1);
      do_clear();
      chk("t6_win_cleared", int'(win), 0);
`endif

      // random traffic
      do_clear();
      for (int i = 0; i < 30; i++) begin
         int act;
         act = int'($urandom_range(0, 9));
         if (act == 0) begin
            do_clear();
         end else if (act == 1) begin
            drop_col = 3'($urandom_range(0, 7));
            clear_req = 1'b1; drop_req = 1'b1;
            tick();
            clear_req = 1'b0; drop_req = 1'b0;
         end else begin
            do_drop(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    a_ack, a_rej, a_b2, a_d2, a_y);
         end
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
